// File: rtl/bytes8_word32_if.sv
// Byte-lane receive bus: incoming byte stream and reassembled 32-bit word output.
interface bytes8_word32_if;
  logic        valid_in;
  logic [7:0]  Data_in;
  logic        valid_out;
  logic [31:0] Data_out;

  modport master (
    output valid_in,
    output Data_in,
    input  valid_out,
    input  Data_out
  );

  modport slave (
    input  valid_in,
    input  Data_in,
    output valid_out,
    output Data_out
  );
endinterface

// File: rtl/bytes8_word32.sv
// Reassembles a clk_4f byte stream into 32-bit words with a one-cycle valid strobe.
// Word alignment comes only from reset release and the count of valid bytes.
module bytes8_word32 #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk_4f,
  input  logic            reset,
  bytes8_word32_if.slave  bus
);

  logic [1:0]  byte_cnt;
  logic [1:0]  lane;
  logic [31:0] asm_q;
  logic [31:0] asm_next;
  logic [31:0] word_q;
  logic        valid_q;
  logic        word_done;

  // Byte index 0 lands in the top lane when MSB_FIRST, otherwise in the bottom lane.
  always_comb begin
    lane = MSB_FIRST ? ~byte_cnt : byte_cnt;
  end

  // The completing byte is merged combinationally so the word is ready on the same edge.
  always_comb begin
    asm_next = asm_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (lane == i[1:0]) begin
        asm_next[i*8 +: 8] = bus.Data_in;
      end
    end
  end

  always_comb begin
    word_done = bus.valid_in && (byte_cnt == 2'd3);
  end

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      byte_cnt <= '0;
      asm_q    <= '0;
      word_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= word_done;
      if (bus.valid_in) begin
        byte_cnt <= byte_cnt + 2'd1;
        asm_q    <= asm_next;
      end
      if (word_done) begin
        word_q <= asm_next;
      end
    end
  end

  assign bus.valid_out = valid_q;
  assign bus.Data_out  = word_q;

endmodule

// File: tb/tb_bytes8_word32.sv
// Directed bench for bytes8_word32: MSB-first and LSB-first instances fed the same bytes.
module tb_bytes8_word32;

  logic        clk_4f;
  logic        reset;
  logic        valid_in;
  logic [7:0]  Data_in;

  int unsigned n_tests;
  int unsigned n_fail;

  bytes8_word32_if if_m ();
  bytes8_word32_if if_l ();

  assign if_m.valid_in = valid_in;
  assign if_m.Data_in  = Data_in;
  assign if_l.valid_in = valid_in;
  assign if_l.Data_in  = Data_in;

  bytes8_word32 #(.MSB_FIRST(1'b1)) dut_m (
    .clk_4f (clk_4f),
    .reset  (reset),
    .bus    (if_m.slave)
  );

  bytes8_word32 #(.MSB_FIRST(1'b0)) dut_l (
    .clk_4f (clk_4f),
    .reset  (reset),
    .bus    (if_l.slave)
  );

  initial clk_4f = 1'b0;
  always #5 clk_4f = ~clk_4f;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read at the same point.
  task automatic step(input logic v, input logic [7:0] d);
    valid_in = v;
    Data_in  = d;
    @(posedge clk_4f);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] w);
    check({tag, "_vld"}, {31'd0, if_m.valid_out}, {31'd0, v});
    check({tag, "_dat"}, if_m.Data_out, w);
  endtask

  logic [31:0] words [3];
  logic [31:0] w;

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    reset    = 1'b0;
    valid_in = 1'b0;
    Data_in  = 8'h00;
    words[0] = 32'hFFFFFFFF;
    words[1] = 32'h00000000;
    words[2] = 32'h12345678;

    repeat (3) @(posedge clk_4f);
    #1;
    expect_out("rst", 1'b0, 32'h0);
    check("rst_l_dat", if_l.Data_out, 32'h0);
    reset = 1'b1;

    // Single word, both byte orders
    step(1'b1, 8'hDE); expect_out("t1_b0", 1'b0, 32'h0);
    step(1'b1, 8'hAD); expect_out("t1_b1", 1'b0, 32'h0);
    step(1'b1, 8'hBE); expect_out("t1_b2", 1'b0, 32'h0);
    step(1'b1, 8'hEF); expect_out("t1_b3", 1'b1, 32'hDEADBEEF);
    check("t1_l_vld", {31'd0, if_l.valid_out}, 32'd1);
    check("t1_l_dat", if_l.Data_out, 32'hEFBEADDE);
    step(1'b0, 8'h00); expect_out("t1_idle", 1'b0, 32'hDEADBEEF);
    check("t1_l_hold", if_l.Data_out, 32'hEFBEADDE);

    // Continuous stream 01..08
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 8'(i));
      if (i == 4)      expect_out("t2_w0", 1'b1, 32'h01020304);
      else if (i == 8) expect_out("t2_w1", 1'b1, 32'h05060708);
      else if (i > 4)  expect_out("t2_mid", 1'b0, 32'h01020304);
      else             expect_out("t2_pre", 1'b0, 32'hDEADBEEF);
    end
    check("t2_l_dat", if_l.Data_out, 32'h08070605);
    step(1'b0, 8'h00); expect_out("t2_idle", 1'b0, 32'h05060708);

    // Gap inside a word, garbage on Data_in while invalid
    step(1'b1, 8'h11); expect_out("t3_b0", 1'b0, 32'h05060708);
    step(1'b1, 8'h22); expect_out("t3_b1", 1'b0, 32'h05060708);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'hFF); expect_out("t3_gap", 1'b0, 32'h05060708);
    end
    step(1'b1, 8'h33); expect_out("t3_b2", 1'b0, 32'h05060708);
    step(1'b1, 8'h44); expect_out("t3_b3", 1'b1, 32'h11223344);
    check("t3_l_dat", if_l.Data_out, 32'h44332211);
    step(1'b0, 8'h00); expect_out("t3_idle", 1'b0, 32'h11223344);

    // Async reset mid-word discards partial bytes
    step(1'b1, 8'hAA);
    step(1'b1, 8'hBB);
    step(1'b1, 8'hCC); expect_out("t4_pre", 1'b0, 32'h11223344);
    valid_in = 1'b0;
    #2 reset = 1'b0;
    #1 expect_out("t4_rst", 1'b0, 32'h0);
    step(1'b1, 8'h99); expect_out("t4_hold", 1'b0, 32'h0);
    reset = 1'b1;
    step(1'b1, 8'h10); expect_out("t4_b0", 1'b0, 32'h0);
    step(1'b1, 8'h20); expect_out("t4_b1", 1'b0, 32'h0);
    step(1'b1, 8'h30); expect_out("t4_b2", 1'b0, 32'h0);
    step(1'b1, 8'h40); expect_out("t4_b3", 1'b1, 32'h10203040);
    check("t4_l_dat", if_l.Data_out, 32'h40302010);

    // Reset while the strobe is high drops it without waiting for a clock
    valid_in = 1'b0;
    #2 reset = 1'b0;
    #1 expect_out("t4_vrst", 1'b0, 32'h0);
    @(posedge clk_4f);
    #1 reset = 1'b1;

    // Loopback through a behavioural MSB-first serializer, one idle cycle between words
    for (int n = 0; n < 3; n++) begin
      w = words[n];
      for (int k = 0; k < 4; k++) begin
        step(1'b1, w[31 - 8*k -: 8]);
        if (k == 3) expect_out($sformatf("lb%0d_word", n), 1'b1, w);
        else        expect_out($sformatf("lb%0d_part", n), 1'b0, (n == 0) ? 32'h0 : words[n-1]);
      end
      step(1'b0, 8'h00);
      expect_out($sformatf("lb%0d_idle", n), 1'b0, w);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
